// File: rtl/rv32_decode_stage.sv
// RV32I decode stage: field split, format class, immediate and usage flags, behind a 2-entry skid buffer.
// Optional illegal-instruction check is built when RV32_DECODE_ILLEGAL_CHECK_EN is defined.
//
//   state | meaning
//   EMPTY | M and S empty, in_ready=1, out_valid=0
//   ONE   | M holds the presented instruction, S empty
//   TWO   | M presented, S holds the next one, in_ready=0
module rv32_decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_rs1_used,
  output logic            out_rs2_used,
  output logic            out_rd_we,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_INV = 3'd7;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [6:0]      opcode;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            rs1_used;
    logic            rs2_used;
    logic            rd_we;
    logic            illegal;
  } dec_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  dec_t        m_q, m_d, s_q, s_d;
  dec_t        dec_in;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] imm32;
  logic        accept, drain;

  always_comb begin
    dec_in        = '0;
    imm32         = '0;
    dec_in.pc     = in_pc;
    dec_in.opcode = in_instr[6:0];
    dec_in.rd     = in_instr[11:7];
    dec_in.funct3 = in_instr[14:12];
    dec_in.rs1    = in_instr[19:15];
    dec_in.rs2    = in_instr[24:20];
    dec_in.funct7 = in_instr[31:25];

    case (in_instr[6:0])
      7'b0110011:                                     dec_in.fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b0001111, 7'b1110011:                         dec_in.fmt = FMT_I;
      7'b0100011:                                     dec_in.fmt = FMT_S;
      7'b1100011:                                     dec_in.fmt = FMT_B;
      7'b0110111, 7'b0010111:                         dec_in.fmt = FMT_U;
      7'b1101111:                                     dec_in.fmt = FMT_J;
      default:                                        dec_in.fmt = FMT_INV;
    endcase

    case (dec_in.fmt)
      FMT_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U:   imm32 = {in_instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    // Signed cast makes the widening replicate instr[31] for XLEN=64.
    dec_in.imm = XLEN'($signed(imm32));

    dec_in.rs1_used = (dec_in.fmt == FMT_R) || (dec_in.fmt == FMT_I) ||
                      (dec_in.fmt == FMT_S) || (dec_in.fmt == FMT_B);
    dec_in.rs2_used = (dec_in.fmt == FMT_R) || (dec_in.fmt == FMT_S) ||
                      (dec_in.fmt == FMT_B);
    dec_in.rd_we    = ((dec_in.fmt == FMT_R) || (dec_in.fmt == FMT_I) ||
                       (dec_in.fmt == FMT_U) || (dec_in.fmt == FMT_J)) &&
                      (dec_in.rd != 5'd0);

`ifdef RV32_DECODE_ILLEGAL_CHECK_EN
    dec_in.illegal =
        (in_instr[1:0] != 2'b11) ||
        (dec_in.fmt == FMT_INV) ||
        ((dec_in.opcode == 7'b0110011) &&
         (dec_in.funct7 != 7'b0000000) && (dec_in.funct7 != 7'b0100000)) ||
        ((dec_in.opcode == 7'b0110011) && (dec_in.funct7 == 7'b0100000) &&
         (dec_in.funct3 != 3'b000) && (dec_in.funct3 != 3'b101)) ||
        ((dec_in.opcode == 7'b0010011) && (dec_in.funct3 == 3'b001) &&
         (dec_in.funct7 != 7'b0000000)) ||
        ((dec_in.opcode == 7'b0010011) && (dec_in.funct3 == 3'b101) &&
         (dec_in.funct7 != 7'b0000000) && (dec_in.funct7 != 7'b0100000));
    if (dec_in.illegal) dec_in.rd_we = 1'b0;
`else
    dec_in.illegal = 1'b0;
`endif
  end

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            m_d     = dec_in;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            m_d = dec_in;
          end else if (accept) begin
            state_d = ST_TWO;
            s_d     = dec_in;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            state_d = ST_ONE;
            m_d     = s_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      s_q         <= s_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_pc       = m_q.pc;
  assign out_rs1      = m_q.rs1;
  assign out_rs2      = m_q.rs2;
  assign out_rd       = m_q.rd;
  assign out_funct3   = m_q.funct3;
  assign out_funct7   = m_q.funct7;
  assign out_opcode   = m_q.opcode;
  assign out_fmt      = m_q.fmt;
  assign out_imm      = m_q.imm;
  assign out_rs1_used = m_q.rs1_used;
  assign out_rs2_used = m_q.rs2_used;
  assign out_rd_we    = m_q.rd_we;
  assign out_illegal  = m_q.illegal;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: hand-computed decode table streamed through a scoreboard,
// plus stall, flush and asynchronous-reset sequences.
module tb_rv32_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_funct3, out_fmt;
  logic [6:0]  out_funct7, out_opcode;
  logic        out_rs1_used, out_rs2_used, out_rd_we, out_illegal;

  rv32_decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_opcode(out_opcode),
    .out_fmt(out_fmt), .out_imm(out_imm),
    .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        r1u, r2u, we, ill;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc;
  } exp_t;

  localparam int NV = 11;
  vec_t vec [NV];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  int   n_acc  = 0;
  int   n_out  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic exp_ill(input vec_t v);
`ifdef RV32_DECODE_ILLEGAL_CHECK_EN
    return v.ill;
`else
    return 1'b0;
`endif
  endfunction

  task automatic cmp_out(input exp_t e);
    chk("pc",      out_pc,       e.pc);
    chk("rs1",     out_rs1,      e.v.rs1);
    chk("rs2",     out_rs2,      e.v.rs2);
    chk("rd",      out_rd,       e.v.rd);
    chk("funct3",  out_funct3,   e.v.f3);
    chk("funct7",  out_funct7,   e.v.f7);
    chk("opcode",  out_opcode,   e.v.op);
    chk("fmt",     out_fmt,      e.v.fmt);
    chk("imm",     out_imm,      e.v.imm);
    chk("rs1_used", out_rs1_used, e.v.r1u);
    chk("rs2_used", out_rs2_used, e.v.r2u);
    chk("rd_we",   out_rd_we,    e.v.we & ~exp_ill(e.v));
    chk("illegal", out_illegal,  exp_ill(e.v));
  endtask

  // Called just after a negedge; inputs are held through the following posedge.
  task automatic step(input logic v, input int idx, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    exp_t e;
    in_valid  = v;
    in_instr  = vec[idx].instr;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
    if (out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual_pc=%0h expected=none", out_pc);
      end else begin
        e = sb.pop_front();
        cmp_out(e);
      end
    end
    if (fl) sb.delete();
    else if (in_valid && in_ready) begin
      e.v  = vec[idx];
      e.pc = pc;
      sb.push_back(e);
      n_acc++;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    //            instr          rs1    rs2    rd     f3    f7      op      fmt   imm            r1u   r2u   we    ill
    vec[0]  = '{32'hFFF10093, 5'd2,  5'd31, 5'd1,  3'd0, 7'h7F, 7'h13, 3'd1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[1]  = '{32'h00512423, 5'd2,  5'd5,  5'd8,  3'd2, 7'h00, 7'h23, 3'd2, 32'h00000008, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[2]  = '{32'h0000006F, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 7'h6F, 3'd5, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{32'h00000000, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 7'h00, 3'd7, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[4]  = '{32'h002081B3, 5'd1,  5'd2,  5'd3,  3'd0, 7'h00, 7'h33, 3'd0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0};
    vec[5]  = '{32'h40209233, 5'd1,  5'd2,  5'd4,  3'd1, 7'h20, 7'h33, 3'd0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b1};
    vec[6]  = '{32'hFE208EE3, 5'd1,  5'd2,  5'd29, 3'd0, 7'h7F, 7'h63, 3'd3, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[7]  = '{32'h123452B7, 5'd8,  5'd3,  5'd5,  3'd5, 7'h09, 7'h37, 3'd4, 32'h12345000, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[8]  = '{32'h001000EF, 5'd0,  5'd1,  5'd1,  3'd0, 7'h00, 7'h6F, 3'd5, 32'h00000800, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[9]  = '{32'h40109093, 5'd1,  5'd1,  5'd1,  3'd1, 7'h20, 7'h13, 3'd1, 32'h00000401, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[10] = '{32'h0000000F, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 7'h0F, 3'd1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_fmt",       out_fmt,   3'd0);
    chk("rst_imm",       out_imm,   32'h0);
    chk("rst_pc",        out_pc,    32'h0);
    chk("rst_rd_we",     out_rd_we, 1'b0);
    chk("rst_illegal",   out_illegal, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // back-to-back stream at full throughput
    for (int i = 0; i < NV; i++) step(1'b1, i, 32'h1000 + 32'(4 * i), 1'b1, 1'b0);
    chk("stream_accepted", n_acc, NV);
    step(1'b0, 0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 0, 32'h0, 1'b1, 1'b0);
    chk("stream_drained", sb.size(), 0);
    chk("stream_outputs", n_out, NV);

    // stall: three instructions with out_ready low
    n0 = n_out;
    step(1'b1, 4, 32'h2000, 1'b0, 1'b0);
    chk("stall_valid", out_valid, 1'b1);
    chk("stall_pc0",   out_pc,    32'h2000);
    chk("stall_rdy1",  in_ready,  1'b1);
    step(1'b1, 1, 32'h2004, 1'b0, 1'b0);
    chk("stall_rdy_lo", in_ready, 1'b0);
    chk("stall_pc1",    out_pc,   32'h2000);
    chk("stall_imm1",   out_imm,  vec[4].imm);
    step(1'b1, 7, 32'h2008, 1'b0, 1'b0);
    chk("stall_pc2",    out_pc,   32'h2000);
    chk("stall_fmt2",   out_fmt,  vec[4].fmt);
    chk("stall_rdy_lo2", in_ready, 1'b0);
    step(1'b1, 7, 32'h2008, 1'b1, 1'b0);
    chk("stall_rdy_back", in_ready, 1'b1);
    step(1'b1, 7, 32'h2008, 1'b1, 1'b0);
    step(1'b0, 0, 32'h0, 1'b1, 1'b0);
    chk("stall_drained", sb.size(), 0);
    chk("stall_count",   n_out - n0, 3);

    // flush in TWO with a valid input in the flush cycle
    step(1'b1, 0, 32'h3000, 1'b0, 1'b0);
    step(1'b1, 2, 32'h3004, 1'b0, 1'b0);
    chk("flush_pre_rdy", in_ready, 1'b0);
    step(1'b1, 8, 32'h3008, 1'b0, 1'b1);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_rdy",   in_ready,  1'b1);
    n0 = n_out;
    step(1'b0, 0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 0, 32'h0, 1'b1, 1'b0);
    chk("flush_no_output", n_out - n0, 0);

    // flush while draining: the drained entry still counts as delivered
    n0 = n_out;
    step(1'b1, 5, 32'h3100, 1'b1, 1'b0);
    step(1'b1, 6, 32'h3104, 1'b1, 1'b1);
    chk("flush_drain_count", n_out - n0, 1);
    chk("flush2_valid", out_valid, 1'b0);
    step(1'b0, 0, 32'h0, 1'b1, 1'b0);
    chk("flush2_empty", sb.size(), 0);

    // asynchronous reset while holding two entries
    step(1'b1, 3, 32'h4000, 1'b0, 1'b0);
    step(1'b1, 8, 32'h4004, 1'b0, 1'b0);
    chk("arst_pre_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_rdy",   in_ready,  1'b1);
    chk("arst_pc",    out_pc,    32'h0);
    chk("arst_fmt",   out_fmt,   3'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 0, 32'h4100, 1'b1, 1'b0);
    step(1'b0, 0, 32'h0, 1'b1, 1'b0);
    chk("arst_after_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_decode_stage.md
# rv32_decode_stage

Registered, handshaked RV32I decode stage between fetch and register-read. It accepts one 32-bit instruction plus PC per cycle, splits the register and function fields, and classifies the instruction format. It also generates the sign-extended immediate and register-use flags, and presents the result through a two-entry skid buffer, so upstream `in_ready` is a pure register output. It supersedes the purely combinational field splitter with back-pressure, flush and immediate generation.

## Interface
- `XLEN`, 32 — datapath width; `out_imm` is sign-extended to XLEN; legal values are 32 and 64.
- `PC_W`, 32 — width of the PC carried alongside the instruction.
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `flush`  in  1  — discards all held and incoming instructions.
- `in_valid`  in  1  — upstream instruction valid.
- `in_ready`  out  1  — stage can accept; registered.
- `in_instr`  in  32  — raw instruction word.
- `in_pc`  in  PC_W  — PC of `in_instr`.
- `out_valid`  out  1  — decoded instruction valid.
- `out_ready`  in  1  — downstream accepts.
- `out_pc`  out  PC_W  — passed-through PC.
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  — instr[19:15], [24:20], [11:7].
- `out_funct3`  out  3  — instr[14:12].
- `out_funct7`  out  7  — instr[31:25].
- `out_opcode`  out  7  — instr[6:0].
- `out_fmt`  out  3  — format: R=0, I=1, S=2, B=3, U=4, J=5, INVALID=7.
- `out_imm`  out  XLEN  — sign-extended immediate; 0 for R and INVALID.
- `out_rs1_used`, `out_rs2_used`, `out_rd_we`  out  1 each  — operand and write-back usage flags.
- `out_illegal`  out  1  — illegal-instruction flag (see Configuration).

## Operation
- Opcode to format mapping:
  - R: 0110011.
  - I: 0010011, 0000011, 1100111, 0001111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Any other opcode: INVALID.
- Immediates follow standard RV32I bit scatter (I/S/B/U/J). B and J immediates have LSB 0. U immediates have the low 12 bits 0. Bit 31 of the instruction is replicated up to XLEN-1.
- Usage flags:
  - `rs1_used` = format in {R, I, S, B}.
  - `rs2_used` = format in {R, S, B}.
  - `rd_we` = format in {R, I, U, J} and rd≠0.
- Decode is combinational on the input side. Results are captured into the main register (M) or the skid register (S).
- Buffer states:
  - EMPTY: M and S empty.
  - ONE: M holds data.
  - TWO: M and S hold data.
- `in_ready` = !S.valid. `out_valid` = M.valid. Outputs are always driven from M.
- Transitions (accept = `in_valid` & `in_ready`, drain = `out_valid` & `out_ready`):
  - EMPTY + accept → ONE.
  - ONE + accept + drain → ONE (M is replaced).
  - ONE + accept, no drain → TWO (new entry goes into S).
  - ONE + drain, no accept → EMPTY.
  - TWO + drain → ONE, with S moving to M. No accept is possible in TWO.
- `flush`:
  - Has priority over every transition. The next state is EMPTY.
  - An `in_valid` presented in the flush cycle is dropped.
  - A drain in the flush cycle still counts as consumed downstream.
- Reset:
  - All valid bits are 0 and the state is EMPTY.
  - `in_ready` = 1, `out_valid` = 0.
  - All data outputs are 0, and `out_fmt` = 0.
- Reset asserted mid-transfer discards M and S immediately (asynchronous reset).

## Timing
- Latency is one cycle: an instruction accepted on edge N is presented on `out_*` after edge N.
- Throughput is one instruction per cycle while `out_ready` = 1.
- `in_ready` deasserts on the cycle after the skid fills and reasserts on the cycle after the first drain in TWO.
- Output data is stable while `out_valid` & !`out_ready`. There are no combinational paths from `out_ready` to `in_ready`.

## Configuration
- `RV32_DECODE_ILLEGAL_CHECK_EN` defined: `out_illegal` is registered with M/S and asserts when any of the following holds:
  - instr[1:0] ≠ 11.
  - The format is INVALID.
  - An OP instruction has funct7 ∉ {0000000, 0100000}.
  - An OP instruction has funct7 = 0100000 with funct3 ∉ {000, 101}.
  - An OP-IMM SLLI has funct7 ≠ 0.
  - An OP-IMM SRLI/SRAI has funct7 ∉ {0000000, 0100000}.
- When `out_illegal` = 1, `out_rd_we` is forced to 0.
- Macro not defined: `out_illegal` is tied to 0 and no check logic is built. INVALID-format instructions still report `fmt` = 7 and `rd_we` = 0.

## Test plan
- Reset, then `in_instr`=0xFFF10093 (addi x1,x2,-1), `out_ready`=1 → one cycle later:
  - rs1=2, rd=1, fmt=1, imm=0xFFFFFFFF, rd_we=1, rs2_used=0.
- `in_instr`=0x00512423 (sw x5,8(x2)) → fmt=2, rs1=2, rs2=5, imm=8, rd_we=0, rs1_used=rs2_used=1.
- `in_instr`=0x0000006F (jal x0,0) → fmt=5, imm=0, rd_we=0.
- Stream three instructions with `out_ready` held 0:
  - The first stays on the outputs unchanged.
  - `in_ready` goes 0 after the second is accepted.
  - Raising `out_ready` delivers all three in order, with no loss or duplication.
- Stage in TWO state, assert `flush` with `in_valid`=1 → next cycle `out_valid`=0 and `in_ready`=1; the flush-cycle input never appears.
- With the macro defined, `in_instr`=0x00000000 → `out_illegal`=1, fmt=7, rd_we=0.
- With the macro undefined, the same stimulus → `out_illegal`=0, fmt=7, rd_we=0.
